// File: rtl/dense_weight_loader_if.sv
// Parameter-load bus for dense_weight_loader: the valid/ready input word stream plus
// the indexed write port toward the dense layer's weight/bias storage.
interface dense_weight_loader_if #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 64,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned RowW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ColW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;

  logic             wr_en;
  logic             wr_sel;
  logic [RowW-1:0]  wr_row;
  logic [ColW-1:0]  wr_col;
  logic [WIDTH-1:0] wr_data;

  // Host side: drives the stream, observes the writes.
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  wr_en, wr_sel, wr_row, wr_col, wr_data
  );

  // Loader side.
  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output wr_en, wr_sel, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/dense_weight_loader.sv
// Runtime loader: weights (row-major) then biases from a valid/ready stream into indexed writes.
// Optional macro LOADER_CHECKSUM_EN appends a checksum word (negated modulo sum) after the biases.
module dense_weight_loader #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 64,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NFRAC = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  dense_weight_loader_if.slave s_if,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);
  localparam int unsigned RowW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned ColW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(N_IN - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(N_OUT - 1);

  if (NFRAC > WIDTH) begin : g_nfrac_check
    $error("NFRAC must not exceed WIDTH");
  end

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLoadW, StLoadB, StLoadCk, StDone, StErr} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoadW, StLoadB, StDone, StErr} state_e;
`endif

  state_e           r_state, w_state_d;
  logic [RowW-1:0]  r_row, w_row_d;
  logic [ColW-1:0]  r_col, w_col_d;
  logic             r_wr_en, w_wr_en_d;
  logic             r_wr_sel, w_wr_sel_d;
  logic [RowW-1:0]  r_wr_row, w_wr_row_d;
  logic [ColW-1:0]  r_wr_col, w_wr_col_d;
  logic [WIDTH-1:0] r_wr_data, w_wr_data_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_err, w_err_d;
  logic             w_ready;
  logic             w_xfer;

`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic [WIDTH-1:0] w_ck_expect;
  assign w_ck_expect = ~r_sum + WIDTH'(1);
`endif

  assign w_xfer = s_if.s_valid && w_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_row_d     = r_row;
    w_col_d     = r_col;
    w_ready     = 1'b0;
    w_wr_en_d   = 1'b0;
    w_wr_sel_d  = r_wr_sel;
    w_wr_row_d  = r_wr_row;
    w_wr_col_d  = r_wr_col;
    w_wr_data_d = r_wr_data;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
`ifdef LOADER_CHECKSUM_EN
    w_sum_d     = r_sum;
`endif

    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StLoadW;
          w_row_d   = '0;
          w_col_d   = '0;
          w_err_d   = 1'b0;
          w_busy_d  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          w_sum_d   = '0;
`endif
        end
      end

      StLoadW: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          w_wr_en_d   = 1'b1;
          w_wr_sel_d  = 1'b0;
          w_wr_row_d  = r_row;
          w_wr_col_d  = r_col;
          w_wr_data_d = s_if.s_data;
`ifdef LOADER_CHECKSUM_EN
          w_sum_d     = r_sum + s_if.s_data;
`endif
          if (r_col == LastCol) begin
            w_col_d = '0;
            if (r_row == LastRow) begin
              w_row_d   = '0;
              w_state_d = StLoadB;
            end else begin
              w_row_d = r_row + RowW'(1);
            end
          end else begin
            w_col_d = r_col + ColW'(1);
          end
          // Any s_last inside the weight block is early framing; the word still lands.
          if (s_if.s_last) begin
            w_state_d = StErr;
          end
        end
      end

      StLoadB: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          w_wr_en_d   = 1'b1;
          w_wr_sel_d  = 1'b1;
          w_wr_row_d  = '0;
          w_wr_col_d  = r_col;
          w_wr_data_d = s_if.s_data;
`ifdef LOADER_CHECKSUM_EN
          w_sum_d     = r_sum + s_if.s_data;
`endif
          if (r_col == LastCol) begin
            w_col_d = '0;
`ifdef LOADER_CHECKSUM_EN
            w_state_d = s_if.s_last ? StErr : StLoadCk;
`else
            w_state_d = s_if.s_last ? StDone : StErr;
`endif
          end else begin
            w_col_d = r_col + ColW'(1);
            if (s_if.s_last) begin
              w_state_d = StErr;
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      StLoadCk: begin
        // Checksum word is compared, never written.
        w_ready = 1'b1;
        if (w_xfer) begin
          w_state_d = (s_if.s_last && (s_if.s_data == w_ck_expect)) ? StDone : StErr;
        end
      end
`endif

      StDone: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end

      StErr: begin
        w_err_d   = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_sel  <= 1'b0;
      r_wr_row  <= '0;
      r_wr_col  <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_row     <= w_row_d;
      r_col     <= w_col_d;
      r_wr_en   <= w_wr_en_d;
      r_wr_sel  <= w_wr_sel_d;
      r_wr_row  <= w_wr_row_d;
      r_wr_col  <= w_wr_col_d;
      r_wr_data <= w_wr_data_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= w_sum_d;
`endif
    end
  end

  assign s_if.s_ready = w_ready;
  assign s_if.wr_en   = r_wr_en;
  assign s_if.wr_sel  = r_wr_sel;
  assign s_if.wr_row  = r_wr_row;
  assign s_if.wr_col  = r_wr_col;
  assign s_if.wr_data = r_wr_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
endmodule

// File: tb/tb_dense_weight_loader.sv
// Self-checking bench for dense_weight_loader: randomized stream timing/data against a
// word-index model of the expected write sequence (honours LOADER_CHECKSUM_EN).
module tb_dense_weight_loader;
  localparam int N_IN  = 16;
  localparam int N_OUT = 64;
  localparam int W     = 8;
  localparam int RW    = 4;
  localparam int CW    = 6;
  localparam int NW    = N_IN * N_OUT;
  localparam int T     = NW + N_OUT;

  typedef logic [1+RW+CW+W-1:0] entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;

  dense_weight_loader_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(W)) bus ();

  dense_weight_loader #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(W), .NFRAC(4)) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_start(start),
    .s_if   (bus),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] words[$];
  entry_t obs[$];
  int busy_cyc = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (bus.wr_en) obs.push_back({bus.wr_sel, bus.wr_row, bus.wr_col, bus.wr_data});
    if (busy) busy_cyc++;
    if (done) done_cnt++;
  end

  // Model: word k of the stream lands at a position fixed by its index alone.
  function automatic entry_t exp_entry(int k);
    bit sel = (k >= NW);
    int row = sel ? 0 : k / N_OUT;
    int col = sel ? k - NW : k % N_OUT;
    return {sel, RW'(row), CW'(col), words[k]};
  endfunction

  function automatic int first_diff(int n);
    for (int k = 0; k < n && k < obs.size(); k++) begin
      if (obs[k] !== exp_entry(k)) return k;
    end
    return -1;
  endfunction

  // mode 0: k mod 256, 1: random, 2: all 0x01.
  task automatic fill(input int mode);
`ifdef LOADER_CHECKSUM_EN
    logic [W-1:0] sum = '0;
`endif
    words.delete();
    for (int k = 0; k < T; k++) begin
      logic [W-1:0] w;
      case (mode)
        0:       w = W'(k);
        1:       w = W'($urandom);
        default: w = 8'h01;
      endcase
      words.push_back(w);
`ifdef LOADER_CHECKSUM_EN
      sum = sum + w;
`endif
    end
`ifdef LOADER_CHECKSUM_EN
    words.push_back(W'(0) - sum);
`endif
  endtask

  task automatic clear_obs();
    obs.delete();
    busy_cyc = 0;
    done_cnt = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents words[0..n-1] in order; start_idx re-pulses start while that word is offered.
  task automatic drive(input int n, input int last_idx, input int gap_pct, input int start_idx,
                       output int sent);
    sent = 0;
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      bit xfer = 1'b0;
      while (!xfer) begin
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
          bus.s_valid = 1'b0;
          bus.s_data  = W'($urandom);
          bus.s_last  = 1'($urandom);
        end else begin
          bus.s_valid = 1'b1;
          bus.s_data  = words[k];
          bus.s_last  = (k == last_idx);
        end
        start = (k == start_idx);
        @(negedge clk);
        xfer = bus.s_valid && bus.s_ready;
        @(posedge clk); #1;
        start = 1'b0;
        waited++;
        if (!xfer && waited > 200) begin
          errors++;
          checks++;
          $display("FAIL stream_stall: word %0d not accepted after %0d cycles, required accept",
                   k, waited);
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
          return;
        end
      end
      sent++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      errors++;
      checks++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b, required 0", bus.s_ready);
    end
    checks++;
    if ({bus.wr_en, bus.wr_sel, bus.wr_row, bus.wr_col, bus.wr_data} !== 19'd0) begin
      errors++;
      $display("FAIL reset_wr_bus: got en=%b sel=%b row=%0d col=%0d data=%h, required all 0",
               bus.wr_en, bus.wr_sel, bus.wr_row, bus.wr_col, bus.wr_data);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got busy/done/err=%b, required 000", {busy, done, err});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_load();
    int sent, d;
    entry_t e0, e_lw, e_lb;
    fill(0);
    clear_obs();
    do_start();
    drive(words.size(), words.size() - 1, 0, -1, sent);
    wait_idle();
    checks++;
    if (obs.size() != T) begin
      errors++; $display("FAIL full_count: got %0d writes, required %0d", obs.size(), T);
    end
    d = first_diff(T);
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL full_seq: first diff at %0d got %h, required %h", d, obs[d], exp_entry(d));
    end
    e0   = (obs.size() > 0)    ? obs[0]    : 'x;
    e_lw = (obs.size() > 1023) ? obs[1023] : 'x;
    e_lb = (obs.size() > 1087) ? obs[1087] : 'x;
    checks++;
    if (e0 !== {1'b0, 4'd0, 6'd0, 8'h00}) begin
      errors++; $display("FAIL full_first: got %h, required %h", e0, {1'b0, 4'd0, 6'd0, 8'h00});
    end
    checks++;
    if (e_lw !== {1'b0, 4'd15, 6'd63, 8'hFF}) begin
      errors++;
      $display("FAIL full_last_w: got %h, required %h", e_lw, {1'b0, 4'd15, 6'd63, 8'hFF});
    end
    checks++;
    if (e_lb !== {1'b1, 4'd0, 6'd63, 8'h3F}) begin
      errors++;
      $display("FAIL full_last_b: got %h, required %h", e_lb, {1'b1, 4'd0, 6'd63, 8'h3F});
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL full_status: got done=%0d err=%b, required 1/0", done_cnt, err);
    end
    checks++;
    if (busy_cyc != words.size() + 1) begin
      errors++; $display("FAIL full_busy: got %0d cycles, required %0d", busy_cyc, words.size() + 1);
    end
  endtask

  task automatic test_gaps();
    int sent, d;
    fill(1);
    clear_obs();
    do_start();
    drive(words.size(), words.size() - 1, 50, -1, sent);
    wait_idle();
    checks++;
    if (obs.size() != T) begin
      errors++; $display("FAIL gaps_count: got %0d writes, required %0d", obs.size(), T);
    end
    d = first_diff(T);
    checks++;
    if (d !== -1) begin
      errors++;
      $display("FAIL gaps_seq: first diff at %0d got %h, required %h", d, obs[d], exp_entry(d));
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL gaps_status: got done=%0d err=%b, required 1/0", done_cnt, err);
    end
  endtask

  task automatic test_early_last();
    int sent;
    entry_t el;
    fill(0);
    clear_obs();
    do_start();
    drive(500, 499, 20, -1, sent);
    wait_idle();
    // Words offered after the error must not be consumed.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++; $display("FAIL early_ready: got %b, required 0", bus.s_ready);
    end
    bus.s_valid = 1'b0;
    checks++;
    if (obs.size() != 500) begin
      errors++; $display("FAIL early_count: got %0d writes, required 500", obs.size());
    end
    el = (obs.size() > 0) ? obs[obs.size() - 1] : 'x;
    checks++;
    if (el !== {1'b0, 4'd7, 6'd51, 8'hF3}) begin
      errors++; $display("FAIL early_last_wr: got %h, required %h", el, {1'b0, 4'd7, 6'd51, 8'hF3});
    end
    checks++;
    if (err !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL early_status: got err=%b done=%0d, required 1/0", err, done_cnt);
    end
  endtask

  task automatic test_recover();
    int sent, d;
    fill(1);
    clear_obs();
    do_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL recover_start: got err=%b busy=%b, required 0/1", err, busy);
    end
    drive(words.size(), words.size() - 1, 30, -1, sent);
    wait_idle();
    d = first_diff(T);
    checks++;
    if (obs.size() != T || d !== -1) begin
      errors++; $display("FAIL recover_seq: got %0d writes diff@%0d, required %0d/-1", obs.size(), d, T);
    end
    checks++;
    if (done_cnt != 1 || err !== 1'b0) begin
      errors++; $display("FAIL recover_status: got done=%0d err=%b, required 1/0", done_cnt, err);
    end
  endtask

  task automatic test_missing_last();
    int sent, d;
    fill(0);
    clear_obs();
    do_start();
    drive(words.size(), -1, 0, 600, sent);
    wait_idle();
    d = first_diff(T);
    checks++;
    if (obs.size() != T || d !== -1) begin
      errors++; $display("FAIL nolast_seq: got %0d writes diff@%0d, required %0d/-1", obs.size(), d, T);
    end
    checks++;
    if (err !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL nolast_status: got err=%b done=%0d, required 1/0", err, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int sent, d;
    fill(0);
    clear_obs();
    do_start();
    drive(300, -1, 0, -1, sent);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.s_ready, bus.wr_en, bus.wr_sel, bus.wr_row, bus.wr_col, bus.wr_data,
         busy, done, err} !== 23'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b en=%b row=%0d col=%0d data=%h busy=%b err=%b, required 0",
               bus.s_ready, bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, busy, err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs.size() != 300 || done_cnt != 0) begin
      errors++; $display("FAIL midreset_count: got %0d writes done=%0d, required 300/0", obs.size(), done_cnt);
    end
    fill(1);
    clear_obs();
    do_start();
    drive(words.size(), words.size() - 1, 10, -1, sent);
    wait_idle();
    d = first_diff(T);
    checks++;
    if (obs.size() != T || d !== -1 || done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_reload: got %0d writes diff@%0d done=%0d, required %0d/-1/1",
               obs.size(), d, done_cnt, T);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int sent;
    fill(2);
    clear_obs();
    do_start();
    drive(words.size(), words.size() - 1, 0, -1, sent);
    wait_idle();
    checks++;
    if (obs.size() != T || done_cnt != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL ck_good: got %0d writes done=%0d err=%b, required %0d/1/0", obs.size(), done_cnt, err, T);
    end
    words[T] = words[T] + 8'd1;
    clear_obs();
    do_start();
    drive(words.size(), words.size() - 1, 0, -1, sent);
    wait_idle();
    checks++;
    if (obs.size() != T || done_cnt != 0 || err !== 1'b1) begin
      errors++;
      $display("FAIL ck_bad: got %0d writes done=%0d err=%b, required %0d/0/1", obs.size(), done_cnt, err, T);
    end
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    test_reset();
    test_full_load();
    test_gaps();
    test_early_last();
    test_recover();
    test_missing_last();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dense_weight_loader.md
Name: dense_weight_loader

Overview:
- Runtime writer for a dense layer's weight/bias memory. It is the load-side counterpart of the fixed-point weight/bias read interface used by the dense layers.
- Accepts a byte/word stream of signed fixed-point parameters (valid/ready) and issues indexed writes into a weights[N_IN][N_OUT] array and a bias[N_OUT] array.
- Sits between a host/config stream and the dense layer's parameter storage, so parameters can be reloaded without resynthesis.

Parameters:
- N_IN, 16, number of input rows of the weight array
- N_OUT, 64, number of output columns / bias entries
- WIDTH, 8, bit width of each signed fixed-point parameter
- NFRAC, 4, fractional bits; informational, no arithmetic depends on it

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  WIDTH  signed parameter word
- s_last  in  1  marks final word of the load
- wr_en  out  1  write strobe to parameter storage
- wr_sel  out  1  0 = weight array, 1 = bias array
- wr_row  out  $clog2(N_IN)  weight row index (0 when wr_sel=1)
- wr_col  out  $clog2(N_OUT)  weight column / bias index
- wr_data  out  WIDTH  parameter value
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky framing error; cleared by next accepted start

Behaviour:
- Reset values: s_ready=0, wr_en=0, wr_sel=0, wr_row=0, wr_col=0, wr_data=0, busy=0, done=0, err=0; FSM=IDLE; counters=0.
- Stream order: weights row-major (row 0 col 0..N_OUT-1, row 1, ...), then biases 0..N_OUT-1. Total words T = N_IN*N_OUT + N_OUT (1088 at defaults).
- Handshake: a word transfers when s_valid && s_ready. s_ready=1 only in LOAD_W and LOAD_B. s_data is not required to be held once s_ready=0.
- Write timing: each accepted word produces wr_en=1 with registered index/data on the following cycle (latency 1). wr_en is otherwise 0.
- FSM states:
  - IDLE:
    - start=1 → LOAD_W; err cleared; counters zeroed; busy=1 from next cycle.
  - LOAD_W:
    - Each transfer increments col; col wraps N_OUT-1→0 with row+1.
    - Transfer at row=N_IN-1, col=N_OUT-1 → LOAD_B, col=0.
  - LOAD_B:
    - Each transfer increments col.
    - Transfer at col=N_OUT-1 with s_last=1 → DONE.
    - Same transfer with s_last=0 → ERR.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
  - ERR: err=1 (sticky), busy=0 → IDLE. The offending word is still written.
- Early s_last (on any transfer before the final bias) → ERR. That word is written; no further writes occur.
- start while busy is ignored. start is sampled in IDLE only, including the cycle after DONE/ERR.
- s_valid while not ready: the word is not consumed and no write occurs.
- Reset mid-load: immediately returns to IDLE with all outputs at reset values. Any partial writes already issued remain in storage; no done pulse.
- Data passes through unmodified: no saturation or sign extension.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the final bias transfer, the FSM enters LOAD_CK and accepts one extra word, which carries s_last.
  - The loader keeps a running WIDTH-bit modulo sum of all T parameter words (wrap-around, unsigned arithmetic).
  - Checksum word = two's-complement negation of that sum; match → DONE, mismatch → ERR. The checksum word is not written.
  - Framing rule: s_last on the final bias word → ERR.
- Undefined: no LOAD_CK state, no sum logic; framing exactly as above.

Test Plan:
- Full load at defaults, s_valid always 1, word k = k mod 256 → 1088 writes in order: first (sel0,r0,c0,0x00), last weight (sel0,r15,c63,0xFF), bias 63 = 0x3F. done pulses once, err=0, busy high for 1088+1 cycles.
- Random s_valid gaps (50%) with the same data → identical write sequence. wr_en count = 1088, no write on idle cycles.
- s_last asserted on word 500 → 500 writes (last at r7,c51), err=1, no done. Next start clears err and a clean load succeeds.
- s_last missing on word 1087 → err=1 after 1088 writes. A second start pulse during a load has no effect.
- reset asserted at word 300 → next cycle all outputs 0, FSM IDLE. A following start + full load → done.
- LOADER_CHECKSUM_EN, all words 0x01 → correct checksum 0xC0 (sum 0x40 mod 256). Sending 0xC0 → done; sending 0xC1 → err. 1088 writes in both cases.
